// File: rtl/tt_pkg.sv
// tt_pkg: shared types and constants for the truth table sequencer.
package tt_pkg;
    localparam int N_VARS = 4;
    localparam int N_ROWS = 16;
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} tt_state_t;
    localparam logic [N_ROWS-1:0] POS_B_EXPECTED = 16'h7FB8;
    function automatic logic [N_VARS:0] row_count(input logic [N_VARS-1:0] first, input logic [N_VARS-1:0] last);
        return {1'b0, last - first} + 5'd1;
    endfunction
endpackage

// File: rtl/tt_index_gen.sv
// tt_index_gen: wrapping row counter with load/step and a last-row compare.
module tt_index_gen
    import tt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              step,
    input  logic [N_VARS-1:0] first,
    input  logic [N_VARS-1:0] last,
    output logic [N_VARS-1:0] idx,
    output logic              is_last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else
            idx <= clear ? '0 : load ? first : step ? idx + 1'b1 : idx;
    end
    assign is_last = (idx == last);
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps a row range onto a 4-input unit, samples f
// after a settle time and compares the captured table with an expected mask.
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_VARS-1:0] first_idx,
    input  logic [N_VARS-1:0] last_idx,
    input  logic [N_ROWS-1:0] expected,
    output logic [N_VARS-1:0] abcd,
    input  logic              f,
    output logic              busy,
    output logic              done,
    output logic [N_ROWS-1:0] table_out,
    output logic              pass,
    output logic [4:0]        mismatch_cnt,
    output logic [N_VARS-1:0] first_mismatch,
    output logic              mismatch_valid
);
    tt_state_t         state;
    logic [3:0]        settle_cnt;
    logic [N_VARS-1:0] last_q;
    logic [N_ROWS-1:0] exp_q;
    logic [N_VARS-1:0] idx;
    logic              is_last;
    logic              accept;
    logic              abort_run;
    logic              sample_end;
    logic              miss;
    logic [4:0]        cnt_next;

    assign accept     = (state == IDLE) && start && !abort;
    assign abort_run  = abort && ((state == WAIT) || (state == SAMPLE));
    assign sample_end = (state == SAMPLE) && !abort;
    assign miss       = f != exp_q[idx];
    assign cnt_next   = mismatch_cnt + {4'd0, miss};
    assign abcd       = idx;

    tt_index_gen u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (abort_run),
        .load    (accept),
        .step    (sample_end),
        .first   (first_idx),
        .last    (last_q),
        .idx     (idx),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            last_q         <= '0;
            exp_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            table_out      <= '0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            mismatch_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state          <= WAIT;
                    settle_cnt     <= '0;
                    last_q         <= last_idx;
                    exp_q          <= expected;
                    busy           <= 1'b1;
                    table_out      <= '0;
                    pass           <= 1'b0;
                    mismatch_cnt   <= '0;
                    first_mismatch <= '0;
                    mismatch_valid <= 1'b0;
                end
                WAIT: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pass  <= 1'b0;
                end else begin
                    state      <= (settle_cnt == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : WAIT;
                    settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pass  <= 1'b0;
                end else begin
                    table_out[idx] <= f;
                    mismatch_cnt   <= cnt_next;
                    if (miss && !mismatch_valid) begin
                        first_mismatch <= idx;
                        mismatch_valid <= 1'b1;
                    end
                    settle_cnt <= '0;
                    state      <= is_last ? DONE : WAIT;
                    busy       <= !is_last;
                    done       <= is_last;
                    pass       <= is_last && (cnt_next == 5'd0);
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: random and directed sweeps of two sequencers
// (settle 1 and settle 3) against a row-by-row truth table model.
module tb_truth_table_sequencer;
    import tt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  first_idx = '0;
    logic [3:0]  last_idx = '0;
    logic [15:0] expected = '0;
    logic [15:0] fn_tab = POS_B_EXPECTED;
    logic        sel = 1'b0;
    logic        start_w [2];
    logic [3:0]  abcd_w [2];
    logic        f_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] table_w [2];
    logic        pass_w [2];
    logic [4:0]  cnt_w [2];
    logic [3:0]  fm_w [2];
    logic        mv_w [2];
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .expected(expected),
        .abcd(abcd_w[0]), .f(f_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .table_out(table_w[0]), .pass(pass_w[0]), .mismatch_cnt(cnt_w[0]),
        .first_mismatch(fm_w[0]), .mismatch_valid(mv_w[0])
    );

    truth_table_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .expected(expected),
        .abcd(abcd_w[1]), .f(f_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .table_out(table_w[1]), .pass(pass_w[1]), .mismatch_cnt(cnt_w[1]),
        .first_mismatch(fm_w[1]), .mismatch_valid(mv_w[1])
    );

    // behavioural function units: arbitrary 4-input tables
    assign f_w[0] = fn_tab[abcd_w[0]];
    assign f_w[1] = fn_tab[abcd_w[1]];

    task automatic test_reset_state();
        for (int i = 0; i < 2; i++) begin
            vecs++; if (abcd_w[i] !== 4'd0) begin errs++; $display("FAIL reset_abcd dut%0d got %h want 0", i, abcd_w[i]); end
            vecs++; if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || pass_w[i] !== 1'b0 || mv_w[i] !== 1'b0) begin
                errs++; $display("FAIL reset_flags dut%0d busy=%b done=%b pass=%b mv=%b want all 0", i, busy_w[i], done_w[i], pass_w[i], mv_w[i]);
            end
            vecs++; if (table_w[i] !== 16'd0 || cnt_w[i] !== 5'd0 || fm_w[i] !== 4'd0) begin
                errs++; $display("FAIL reset_results dut%0d table=%h cnt=%0d fm=%0d want 0", i, table_w[i], cnt_w[i], fm_w[i]);
            end
        end
    endtask

    task automatic sweep(input logic [3:0] fi, input logic [3:0] la, input logic [15:0] ex, input bit poke);
        int s, n;
        logic [15:0] tab;
        logic [4:0]  cnt;
        logic [3:0]  fm, row;
        logic        mv;
        s = sel ? 3 : 1;
        n = int'(4'(la - fi)) + 1;
        tab = '0; cnt = '0; fm = '0; mv = 1'b0;
        for (int r = 0; r < n; r++) begin
            row = 4'(fi + 4'(r));
            tab[row] = fn_tab[row];
            if (fn_tab[row] != ex[row]) begin
                cnt++;
                if (!mv) begin fm = row; mv = 1'b1; end
            end
        end
        @(negedge clk);
        first_idx = fi; last_idx = la; expected = ex; start_w[sel] = 1'b1;
        @(posedge clk); #1;
        start_w[sel] = 1'b0;
        for (int k = 1; k <= n * (s + 1); k++) begin
            vecs++; if (abcd_w[sel] !== 4'(fi + 4'((k - 1) / (s + 1))) || busy_w[sel] !== 1'b1 || done_w[sel] !== 1'b0) begin
                errs++; $display("FAIL sweep_cycle k=%0d abcd=%h busy=%b done=%b want abcd=%h busy=1 done=0", k, abcd_w[sel], busy_w[sel], done_w[sel], 4'(fi + 4'((k - 1) / (s + 1))));
            end
            if (poke && k == 3) begin start_w[sel] = 1'b1; first_idx = fi + 4'd8; end
            if (poke && k == 4) begin start_w[sel] = 1'b0; first_idx = fi; end
            @(posedge clk); #1;
        end
        vecs++; if (done_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0) begin
            errs++; $display("FAIL sweep_done fi=%0d la=%0d done=%b busy=%b want done=1 busy=0", fi, la, done_w[sel], busy_w[sel]);
        end
        vecs++; if (table_w[sel] !== tab) begin errs++; $display("FAIL sweep_table got %h want %h", table_w[sel], tab); end
        vecs++; if (cnt_w[sel] !== cnt || mv_w[sel] !== mv || (mv && fm_w[sel] !== fm)) begin
            errs++; $display("FAIL sweep_mismatch cnt=%0d mv=%b fm=%0d want cnt=%0d mv=%b fm=%0d", cnt_w[sel], mv_w[sel], fm_w[sel], cnt, mv, fm);
        end
        vecs++; if (pass_w[sel] !== (cnt == 5'd0)) begin errs++; $display("FAIL sweep_pass got %b want %b", pass_w[sel], cnt == 5'd0); end
        @(posedge clk); #1;
        vecs++; if (done_w[sel] !== 1'b0 || table_w[sel] !== tab) begin
            errs++; $display("FAIL sweep_hold done=%b table=%h want done=0 table=%h", done_w[sel], table_w[sel], tab);
        end
    endtask

    task automatic test_directed();
        sel = 1'b0; fn_tab = POS_B_EXPECTED;
        sweep(4'd0, 4'd15, 16'h7FB8, 1'b0);
        sweep(4'd0, 4'd15, 16'h7FB9, 1'b0);
        sweep(4'd6, 4'd2, 16'h7FB8, 1'b0);
        sel = 1'b1;
        sweep(4'd3, 4'd3, 16'h0000, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; fn_tab = POS_B_EXPECTED;
        sweep(4'd2, 4'd9, 16'h7FB8, 1'b1);
        sweep(4'd10, 4'd1, 16'h0F0F, 1'b1);
        sel = 1'b1;
        sweep(4'd7, 4'd5, 16'hAAAA, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        sel = 1'b0; fn_tab = POS_B_EXPECTED;
        @(negedge clk);
        first_idx = 4'd0; last_idx = 4'd15; expected = POS_B_EXPECTED; start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        vecs++; if (abcd_w[0] !== 4'd5) begin errs++; $display("FAIL abort_row got %0d want 5", abcd_w[0]); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vecs++; if (busy_w[0] !== 1'b0 || abcd_w[0] !== 4'd0 || pass_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errs++; $display("FAIL abort_state busy=%b abcd=%h pass=%b done=%b want 0 0 0 0", busy_w[0], abcd_w[0], pass_w[0], done_w[0]);
        end
        vecs++; if (table_w[0] !== (POS_B_EXPECTED & 16'h001F) || cnt_w[0] !== 5'd0) begin
            errs++; $display("FAIL abort_partial table=%h cnt=%0d want %h 0", table_w[0], cnt_w[0], POS_B_EXPECTED & 16'h001F);
        end
        repeat (40) begin @(posedge clk); #1; saw_done |= done_w[0] | busy_w[0]; end
        vecs++; if (saw_done) begin errs++; $display("FAIL abort_quiet got activity=1 want 0"); end
        abort = 1'b1; start_w[0] = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start_w[0] = 1'b0;
        vecs++; if (busy_w[0] !== 1'b0) begin errs++; $display("FAIL abort_with_start busy=%b want 0", busy_w[0]); end
    endtask

    task automatic test_async_reset();
        sel = 1'b0; fn_tab = 16'hFFFF;
        @(negedge clk);
        first_idx = 4'd0; last_idx = 4'd15; expected = 16'h0000; start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        vecs++; if (busy_w[0] !== 1'b1 || cnt_w[0] !== 5'd2) begin
            errs++; $display("FAIL reset_pre busy=%b cnt=%0d want 1 2", busy_w[0], cnt_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset_state();
        @(negedge clk) rst_n = 1'b1;
        fn_tab = POS_B_EXPECTED;
        sweep(4'd0, 4'd15, 16'h7FB8, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            sel = 1'($urandom_range(0, 1));
            fn_tab = 16'($urandom);
            sweep(4'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0) ? fn_tab : 16'($urandom), 1'($urandom_range(0, 1)));
        end
        sel = 1'b0;
    endtask

    initial begin
        start_w[0] = 1'b0; start_w[1] = 1'b0;
        #1;
        test_reset_state();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_directed();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
